// File: rtl/seq_divider.sv
// seq_divider: restoring divider that produces one quotient bit per clock, with a start/done handshake.
// Define SEQ_DIV_SIGNED_EN to treat A, B, Q and R as two's complement; the default build is unsigned.
module seq_divider #(
   parameter int unsigned n = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] Q,
   output logic [n-1:0] R,
   output logic         div_by_zero
);

   localparam int unsigned CW = (n > 2) ? $clog2(n) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t        state_q, state_d;
   logic [n:0]    p_q, p_d, p_shift, diff;
   logic [n-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
   logic [n-1:0]  q_q, q_d, r_q, r_d;
   logic [n-1:0]  a_in, b_in, q_fin, r_fin, r_raw;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dbz_q, dbz_d, done_q, done_d, dz_q, dz_d;
   logic          negq_q, negq_d, negr_q, negr_d, negq_in, negr_in;

`ifdef SEQ_DIV_SIGNED_EN
   // Magnitudes go through the unsigned datapath; signs are restored on the FIN edge.
   always_comb begin
      a_in    = A[n-1] ? -A : A;
      b_in    = B[n-1] ? -B : B;
      negq_in = A[n-1] ^ B[n-1];
      negr_in = A[n-1];
   end
`else
   always_comb begin
      a_in    = A;
      b_in    = B;
      negq_in = 1'b0;
      negr_in = 1'b0;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = (B == '0) ? FIN : RUN;
         RUN:     if (cnt_q == '0) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      p_shift = {p_q[n-1:0], dvd_q[n-1]};
      diff    = p_shift - {1'b0, dvs_q};
      r_raw   = dbz_q ? dvd_q : p_q[n-1:0];
      q_fin   = dbz_q ? '1 : (negq_q ? -dvd_q : dvd_q);
      r_fin   = negr_q ? -r_raw : r_raw;

      p_d    = p_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      dbz_d  = dbz_q;
      negq_d = negq_q;
      negr_d = negr_q;
      q_d    = q_q;
      r_d    = r_q;
      dz_d   = dz_q;
      done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               p_d    = '0;
               dvd_d  = a_in;
               dvs_d  = b_in;
               cnt_d  = CW'(n - 1);
               dbz_d  = (B == '0);
               negq_d = negq_in;
               negr_d = negr_in;
            end
         end
         RUN: begin
            // A non-negative trial difference keeps the subtraction and yields a 1 quotient bit.
            if (!diff[n]) begin
               p_d   = diff;
               dvd_d = {dvd_q[n-2:0], 1'b1};
            end else begin
               p_d   = p_shift;
               dvd_d = {dvd_q[n-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
         end
         FIN: begin
            q_d    = q_fin;
            r_d    = r_fin;
            dz_d   = dbz_q;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q    <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         dbz_q  <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         q_q    <= '0;
         r_q    <= '0;
         dz_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         dbz_q  <= dbz_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         q_q    <= q_d;
         r_q    <= r_d;
         dz_q   <= dz_d;
         done_q <= done_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign Q           = q_q;
   assign R           = r_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;
   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a_s = '0, b_s = '0;
   logic         busy, done, dz;
   logic [N-1:0] q, r;
   int           checks = 0, errors = 0;
   int           cyc = 0;

   seq_divider #(.n(N)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a_s), .B(b_s),
      .busy(busy), .done(done), .Q(q), .R(r), .div_by_zero(dz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] qe, output logic [N-1:0] re,
                                 output logic ze);
`ifdef SEQ_DIV_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
`endif
      if (b == '0) begin
         qe = '1; re = a; ze = 1'b1;
      end else begin
`ifdef SEQ_DIV_SIGNED_EN
         qe = N'(sa / sb);
         re = N'(sa % sb);
`else
         qe = a / b;
         re = a % b;
`endif
         ze = 1'b0;
      end
   endfunction

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise, input string tag);
      logic [N-1:0] qe, re;
      logic         ze;
      int           k;
      bit           got;
      model(a, b, qe, re, ze);
      @(negedge clk);
      a_s = a; b_s = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a_s = N'($urandom); b_s = N'($urandom);
      chk({tag, " busy_after_capture"}, 32'(busy), 32'd1);
      k = 0; got = 1'b0;
      while (!got && k < 40) begin
         @(posedge clk); k++; #1;
         if (noise && k == 3) begin
            start = 1'b1; a_s = N'($urandom); b_s = N'($urandom);
         end else start = 1'b0;
         if (done) got = 1'b1;
      end
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(k + 1), ze ? 32'd2 : 32'(N + 2));
      chk({tag, " busy_with_done"}, 32'(busy), 32'd0);
      chk({tag, " Q"}, 32'(q), 32'(qe));
      chk({tag, " R"}, 32'(r), 32'(re));
      chk({tag, " dbz"}, 32'(dz), 32'(ze));
      @(posedge clk); #1;
      chk({tag, " done_single"}, 32'(done), 32'd0);
      chk({tag, " Q_held"}, 32'(q), 32'(qe));
   endtask

   initial begin
      logic [N-1:0] qe, re;
      logic         ze, saw_done;
      int           d[3];
      int           c0, nd;

      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset Q", 32'(q), 32'd0);
      chk("reset R", 32'(r), 32'd0);
      chk("reset dbz", 32'(dz), 32'd0);
      @(negedge clk); rst = 1'b0;

      do_op(8'd200, 8'd7, 1'b0, "200/7");
      do_op(8'd5,   8'd9, 1'b0, "5/9");
      do_op(8'd255, 8'd1, 1'b0, "255/1");
      do_op(8'd0,   8'd3, 1'b0, "0/3");
      do_op(8'd37,  8'd0, 1'b0, "37/0");
      do_op(8'd10,  8'd3, 1'b0, "10/3");
      do_op(8'd200, 8'd7, 1'b1, "ignore_start");
`ifdef SEQ_DIV_SIGNED_EN
      do_op(8'hF9, 8'd2,  1'b0, "-7/2");
      do_op(8'd7,  8'hFE, 1'b0, "7/-2");
      do_op(8'h80, 8'hFF, 1'b0, "-128/-1");
      do_op(8'h80, 8'd0,  1'b0, "-128/0");
      do_op(8'hF9, 8'hFE, 1'b0, "-7/-2");
`endif

      // start held high: three back-to-back results
      @(negedge clk); a_s = 8'd200; b_s = 8'd7; start = 1'b1;
      @(posedge clk); #1; c0 = cyc;
      nd = 0;
      for (int i = 0; i < 100 && nd < 3; i++) begin
         @(posedge clk); #1;
         if (done) begin
            d[nd] = cyc; nd++;
            chk("held Q", 32'(q), 32'd28);
            chk("held R", 32'(r), 32'd4);
            if (nd == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held count", 32'(nd), 32'd3);
      if (nd == 3) begin
         chk("held first latency", 32'(d[0] - c0 + 1), 32'(N + 2));
         chk("held interval1", 32'(d[1] - d[0]), 32'(N + 2));
         chk("held interval2", 32'(d[2] - d[1]), 32'(N + 2));
      end
      repeat (2) @(posedge clk);

      // reset in the middle of 200/7
      @(negedge clk); a_s = 8'd200; b_s = 8'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst Q", 32'(q), 32'd0);
      chk("midrst R", 32'(r), 32'd0);
      chk("midrst dbz", 32'(dz), 32'd0);
      @(negedge clk); rst = 1'b0;
      saw_done = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      chk("midrst no_done", 32'(saw_done), 32'd0);
      do_op(8'd200, 8'd7, 1'b0, "after_rst");

      for (int i = 0; i < 30; i++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         do_op(ra, rb, 1'(i % 2), "random");
      end

      model(8'd1, 8'd1, qe, re, ze);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
